// File: rtl/invaders_pkg.sv
// Shared state encoding, alien count and default playfield geometry for the
// invaders game blocks.
package invaders_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } game_state_e;

  localparam int NUM_ALIENS = 15;
  localparam logic [NUM_ALIENS-1:0] ALL_ALIVE = 15'h7FFF;

  localparam int DEF_STEP_X      = 4;
  localparam int DEF_STEP_Y      = 8;
  localparam int DEF_X_MIN       = 8;
  localparam int DEF_X_MAX       = 632;
  localparam int DEF_FLEET_W     = 200;
  localparam int DEF_FLEET_H     = 75;
  localparam int DEF_START_X     = 120;
  localparam int DEF_START_Y     = 40;
  localparam int DEF_LOSE_Y      = 420;
  localparam int DEF_BASE_PERIOD = 30;
  localparam int DEF_MIN_PERIOD  = 4;

  localparam int          CNT_W      = 8;
  localparam logic [11:0] SCORE_MAX  = 12'd4095;
  localparam logic [11:0] HIT_POINTS = 12'd10;

  function automatic logic [3:0] count_alive(input logic [NUM_ALIENS-1:0] mask);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_ALIENS; i++) n = n + {3'b000, mask[i]};
    return n;
  endfunction

endpackage

// File: rtl/fleet_stepper.sv
// Combinational fleet step: moves the formation one step sideways, or drops it
// and reverses direction when the next sideways move would cross a bound.
module fleet_stepper
  import invaders_pkg::*;
#(
  parameter int STEP_X  = DEF_STEP_X,
  parameter int STEP_Y  = DEF_STEP_Y,
  parameter int FLEET_W = DEF_FLEET_W
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       dir_left,
  input  logic [9:0] x_min,
  input  logic [9:0] x_max,
  output logic [9:0] next_x,
  output logic [9:0] next_y,
  output logic       next_dir_left
);

  logic [11:0] right_edge;
  logic [11:0] left_limit;
  logic        past_right;
  logic        past_left;

  // Widened so the edge sums cannot wrap near the top of the 10-bit range.
  assign right_edge = {2'b00, x} + 12'(FLEET_W) + 12'(STEP_X);
  assign left_limit = {2'b00, x_min} + 12'(STEP_X);
  assign past_right = right_edge > {2'b00, x_max};
  assign past_left  = {2'b00, x} < left_limit;

  always_comb begin
    next_x        = x;
    next_y        = y;
    next_dir_left = dir_left;
    if (!dir_left) begin
      if (past_right) begin
        next_y        = y + 10'(STEP_Y);
        next_dir_left = 1'b1;
      end else begin
        next_x = x + 10'(STEP_X);
      end
    end else begin
      if (past_left) begin
        next_y        = y + 10'(STEP_Y);
        next_dir_left = 1'b0;
      end else begin
        next_x = x - 10'(STEP_X);
      end
    end
  end

endmodule

// File: rtl/alien_fleet_ctrl.sv
// Alien fleet controller: game FSM, frame-paced fleet stepping whose speed
// rises as aliens die, hit bookkeeping, score and wave tracking.
module alien_fleet_ctrl
  import invaders_pkg::*;
#(
  parameter int STEP_X      = DEF_STEP_X,
  parameter int STEP_Y      = DEF_STEP_Y,
  parameter int X_MIN       = DEF_X_MIN,
  parameter int X_MAX       = DEF_X_MAX,
  parameter int FLEET_W     = DEF_FLEET_W,
  parameter int FLEET_H     = DEF_FLEET_H,
  parameter int START_X     = DEF_START_X,
  parameter int START_Y     = DEF_START_Y,
  parameter int LOSE_Y      = DEF_LOSE_Y,
  parameter int BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        hit_valid,
  input  logic [3:0]  hit_idx,
  output logic [1:0]  state,
  output logic [9:0]  fleet_x,
  output logic [9:0]  fleet_y,
  output logic [14:0] alive,
  output logic [11:0] score,
  output logic [3:0]  wave,
  output logic        hit_ack,
  output logic        step_pulse
);

  game_state_e      state_q;
  game_state_e      state_d;
  logic             dir_left;
  logic [CNT_W-1:0] frame_cnt;

  logic             in_play;
  logic             enter_play;
  logic             from_win;
  logic [3:0]       wave_d;
  logic [3:0]       killed;
  int               period_raw;
  logic [CNT_W-1:0] period;
  logic             step_now;
  logic [15:0]      alive_ext;
  logic [14:0]      hit_mask;
  logic             hit_accept;
  logic [10:0]      fleet_bottom;
  logic [9:0]       step_x;
  logic [9:0]       step_y;
  logic             step_dir_left;

  fleet_stepper #(
    .STEP_X  (STEP_X),
    .STEP_Y  (STEP_Y),
    .FLEET_W (FLEET_W)
  ) u_stepper (
    .x             (fleet_x),
    .y             (fleet_y),
    .dir_left      (dir_left),
    .x_min         (10'(X_MIN)),
    .x_max         (10'(X_MAX)),
    .next_x        (step_x),
    .next_y        (step_y),
    .next_dir_left (step_dir_left)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // WIN is checked first so a last kill on the invasion line still wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: if (start) state_d = ST_PLAY;
      ST_PLAY: begin
        if (alive == '0)                       state_d = ST_WIN;
        else if (fleet_bottom >= 11'(LOSE_Y))  state_d = ST_LOSE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    state      = state_q;
    in_play    = (state_q == ST_PLAY);
    from_win   = (state_q == ST_WIN);
    enter_play = (state_q != ST_PLAY) && (state_d == ST_PLAY);
  end

  assign fleet_bottom = {1'b0, fleet_y} + 11'(FLEET_H);
  assign wave_d       = from_win ? ((wave == 4'hF) ? wave : wave + 4'd1) : 4'd0;
  assign killed       = 4'(NUM_ALIENS) - count_alive(alive);

  // Signed so a large kill count clamps to MIN_PERIOD instead of wrapping.
  always_comb begin
    period_raw = BASE_PERIOD - 2 * int'(killed);
    if (period_raw < MIN_PERIOD) period_raw = MIN_PERIOD;
    period = CNT_W'(period_raw);
  end

  // ">=" keeps the counter from running past a period that just shrank.
  assign step_now   = in_play && frame_tick && (frame_cnt >= period - CNT_W'(1));
  assign alive_ext  = {1'b0, alive};
  assign hit_mask   = 15'(16'd1 << hit_idx);
  assign hit_accept = in_play && hit_valid && (hit_idx < 4'(NUM_ALIENS)) && alive_ext[hit_idx];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fleet_x    <= 10'(START_X);
      fleet_y    <= 10'(START_Y);
      alive      <= ALL_ALIVE;
      score      <= '0;
      wave       <= '0;
      dir_left   <= 1'b0;
      frame_cnt  <= '0;
      hit_ack    <= 1'b0;
      step_pulse <= 1'b0;
    end else if (enter_play) begin
      fleet_x    <= 10'(START_X);
      fleet_y    <= 10'(START_Y) + {3'b000, wave_d, 3'b000};
      alive      <= ALL_ALIVE;
      wave       <= wave_d;
      dir_left   <= 1'b0;
      frame_cnt  <= '0;
      hit_ack    <= 1'b0;
      step_pulse <= 1'b0;
      if (!from_win) score <= '0;
    end else begin
      hit_ack    <= hit_accept;
      step_pulse <= step_now;
      if (in_play && frame_tick) frame_cnt <= step_now ? '0 : frame_cnt + CNT_W'(1);
      if (step_now) begin
        fleet_x  <= step_x;
        fleet_y  <= step_y;
        dir_left <= step_dir_left;
      end
      if (hit_accept) begin
        alive <= alive & ~hit_mask;
        score <= (score > SCORE_MAX - HIT_POINTS) ? SCORE_MAX : score + HIT_POINTS;
      end
    end
  end

endmodule

// File: doc/alien_fleet_ctrl.md
ALIEN_FLEET_CTRL -- requirements
Module: alien_fleet_ctrl

Interface
REQ-001 SHALL have parameter STEP_X, default 4, fleet horizontal step in pixels.
REQ-002 SHALL have parameter STEP_Y, default 8, fleet drop in pixels on an edge reversal.
REQ-003 SHALL have parameters X_MIN = 8 and X_MAX = 632, the horizontal fleet bounds in pixels.
REQ-004 SHALL have parameters FLEET_W = 200 and FLEET_H = 75, the formation extent (5 cols x 40 px, 3 rows x 25 px).
REQ-005 SHALL have parameters START_X = 120 and START_Y = 40, the origin of wave 0.
REQ-006 SHALL have parameter LOSE_Y, default 420, the invasion line.
REQ-007 SHALL have parameters BASE_PERIOD = 30 and MIN_PERIOD = 4, in frames per step.
REQ-008 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-009 Port list (name, direction, width, meaning):
- Clk, in, 1: system clock (50 MHz).
- Reset, in, 1: synchronous, active-high reset.
- frame_tick, in, 1: one-cycle pulse per video frame.
- start, in, 1: one-cycle pulse that begins or continues play.
- hit_valid, in, 1: missile-to-alien collision report.
- hit_idx, in, 4: alien index, 0-14, row-major.
- state, out, 2: IDLE=0, PLAY=1, WIN=2, LOSE=3.
- fleet_x, out, 10: top-left X of alien 0.
- fleet_y, out, 10: top-left Y of alien 0.
- alive, out, 15: per-alien alive mask.
- score, out, 12: running score.
- wave, out, 4: wave number.
- hit_ack, out, 1: one-cycle pulse for an accepted hit.
- step_pulse, out, 1: one-cycle pulse on each fleet step.

Function
REQ-010 SHALL run an FSM with states IDLE, PLAY, WIN and LOSE.
REQ-011 FSM transitions SHALL be:
- IDLE to PLAY on start.
- PLAY to WIN when alive==0.
- PLAY to LOSE when fleet_y+FLEET_H >= LOSE_Y.
- WIN or LOSE to PLAY on start.
REQ-012 If the WIN and LOSE conditions hold in the same cycle, WIN SHALL take priority.
REQ-013 On entering PLAY, SHALL reload the fleet state:
- fleet_x=START_X.
- fleet_y=START_Y+8*wave.
- alive=15'h7FFF.
- dir=right.
- frame counter cleared.
REQ-014 Start from LOSE or IDLE SHALL clear score and wave.
REQ-015 Start from WIN SHALL increment wave, saturating at 15, and retain score.
REQ-016 In PLAY, SHALL count frame_ticks; when the count reaches period-1 on a tick, SHALL step, clear the counter and pulse step_pulse for one cycle.
REQ-017 Step period SHALL be max(MIN_PERIOD, BASE_PERIOD - 2*killed), where killed = 15 - popcount(alive).
REQ-018 The period SHALL be recomputed combinationally each cycle.
REQ-019 Step right SHALL apply: if fleet_x+FLEET_W+STEP_X > X_MAX, then fleet_y += STEP_Y and dir=left; else fleet_x += STEP_X.
REQ-020 Step left SHALL apply: if fleet_x < X_MIN+STEP_X, then fleet_y += STEP_Y and dir=right; else fleet_x -= STEP_X.
REQ-021 A drop step SHALL never also change fleet_x.
REQ-022 In PLAY, a hit with hit_idx<15 and alive[hit_idx]=1 SHALL:
- clear alive[hit_idx] on the next edge;
- add 10 to score, saturating at 4095;
- pulse hit_ack one cycle later.
REQ-023 Hits with hit_idx>=15, on a dead alien, or outside PLAY SHALL be ignored, with no hit_ack.
REQ-024 A hit and a step in the same cycle SHALL both take effect.
REQ-025 The end-of-game check in that case SHALL use the updated values on the following cycle.
REQ-026 frame_tick and start SHALL have no effect on fleet position while in IDLE, WIN or LOSE.
REQ-027 fleet_x, fleet_y, alive and score SHALL hold their values in IDLE, WIN and LOSE.

Reset
REQ-028 Reset SHALL set the registers to:
- state=IDLE.
- fleet_x=START_X.
- fleet_y=START_Y.
- alive=15'h7FFF.
- score=0, wave=0.
- dir=right.
- frame counter=0.
- hit_ack=0, step_pulse=0.
REQ-029 Reset SHALL override start, hit_valid and frame_tick in the same cycle.
REQ-030 Reset asserted mid-PLAY SHALL return to IDLE on the next edge.

Structure
REQ-031 The state enum, the NUM_ALIENS=15 constant and the default geometry constants SHALL live in the shared package invaders_pkg.
REQ-032 The step and reversal computation SHALL be one sub-module, fleet_stepper; it is combinational and takes x, y, dir and the bounds.
REQ-033 The frame counter, the FSM and the alive/score registers SHALL remain in alien_fleet_ctrl.

Verification
REQ-034 Reset then start, then 30 frame_ticks: fleet_x=124, fleet_y=40, exactly one step_pulse.
REQ-035 Right-edge reversal:
- after 78 steps: fleet_x=432, fleet_y=40;
- 79th step: fleet_x=432, fleet_y=48, dir=left;
- 80th step: fleet_x=428.
REQ-036 Hit handling:
- hit_idx=3 twice, then hit_idx=15: one hit_ack only, alive=15'h7FF7, score=10;
- after 5 distinct kills the period is 20 frames.
REQ-037 Win and continue:
- kill all 15: state=WIN, score=150;
- start: state=PLAY, wave=1, fleet_y=48, alive=15'h7FFF, score=150.
REQ-038 Invasion and reset:
- BASE_PERIOD=1, MIN_PERIOD=1: LOSE is entered when fleet_y reaches >=345;
- start: score=0, wave=0;
- Reset asserted mid-PLAY together with hit_valid: IDLE, alive=15'h7FFF, no hit_ack.
